// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
// Read-side consumer of the async FIFO, in the rclk domain. It pops the FIFO,
// captures the registered rdata one cycle later, and re-presents the words as
// a valid/ready stream through a 2-entry skid buffer.
// The core rate is one word per cycle while out_ready stays high. A
// synchronous flush drops the buffered words and the word in flight.
// Optional feature macro: RD_STREAM_STATS_EN adds the saturating counters
// stat_words and stat_stall.
module async_fifo_rd_stream #(
    parameter int DWIDTH = 8
) (
    input  logic              rclk,
    input  logic              reset_L,
    output logic              pop,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              empty,
    input  logic              flush,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [15:0]       stat_words,
    output logic [15:0]       stat_stall
`endif
);

    // inflight marks that rdata carries a popped word on the coming edge
    logic              inflight;
    logic              drain;
    logic              capture;
    logic [2:0]        level;
    logic [1:0]        occ_nxt;
    logic [DWIDTH-1:0] entry0;
    logic [DWIDTH-1:0] entry1;
    logic [DWIDTH-1:0] e0_nxt;
    logic [DWIDTH-1:0] e1_nxt;

    assign drain    = out_valid & out_ready;
    assign capture  = inflight & ~flush;
    assign out_data = entry0;

    // Words committed after this edge: the buffered entries plus the word in
    // flight minus the one leaving now. Staying below 2 guarantees the word
    // popped now always finds a free slot when it lands next cycle.
    assign level = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, drain};
    assign pop   = reset_L & ~empty & ~flush & (level < 3'd2);

    // Next state of the skid buffer: tail write on capture, shift on drain
    always_comb begin
        occ_nxt = occupancy;
        e0_nxt  = entry0;
        e1_nxt  = entry1;
        if (flush) begin
            occ_nxt = 2'd0;
        end else begin
            case ({capture, drain})
                2'b10: begin
                    occ_nxt = occupancy + 2'd1;
                    if (occupancy == 2'd0) e0_nxt = rdata;
                    else                   e1_nxt = rdata;
                end
                2'b01: begin
                    occ_nxt = occupancy - 2'd1;
                    e0_nxt  = entry1;
                end
                2'b11: begin
                    if (occupancy == 2'd2) begin
                        e0_nxt = entry1;
                        e1_nxt = rdata;
                    end else begin
                        e0_nxt = rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state and head entry; reset loses any word in flight
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            inflight  <= 1'b0;
            occupancy <= 2'd0;
            out_valid <= 1'b0;
            entry0    <= '0;
        end else begin
            inflight  <= pop;
            occupancy <= occ_nxt;
            out_valid <= (occ_nxt != 2'd0);
            entry0    <= e0_nxt;
        end
    end

    // Second entry holds data only, so it needs no reset
    always_ff @(posedge rclk) begin
        entry1 <= e1_nxt;
    end

    // The pop throttle makes a capture into a full, non-draining buffer impossible
    overflow_chk: assert property (@(posedge rclk) disable iff (!reset_L)
        !(capture && occupancy == 2'd2 && !drain));

`ifdef RD_STREAM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counters of delivered words and back-pressured cycles
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            stat_words <= 16'd0;
            stat_stall <= 16'd0;
        end else if (flush) begin
            stat_words <= 16'd0;
            stat_stall <= 16'd0;
        end else begin
            if (drain)                  stat_words <= sat_inc(stat_words);
            if (out_valid & ~out_ready) stat_stall <= sat_inc(stat_stall);
        end
    end
`endif

endmodule
